// File: rtl/pc_sequencer_if.sv
// Fetch/execute sequencer bus: decoder and ALU status in, program counter and strobes out.
// The sequencer takes the slave side; the ROM/decoder side takes the master side.
interface pc_sequencer_if #(
  parameter int PW = 10
);
  logic          Start;
  logic [8:0]    Instr;
  logic          Branch;
  logic          FlagWrite;
  logic [2:0]    Flag;
  logic          LoadOp;
  logic          StatusEn;
  logic          Zero;
  logic          Neg;
  logic [PW-1:0] Target;
  logic [PW-1:0] ProgCtr;
  logic          FetchEn;
  logic          ExecEn;
  logic          Done;

  modport master (
    output Start, Instr, Branch, FlagWrite, Flag, LoadOp, StatusEn, Zero, Neg, Target,
    input  ProgCtr, FetchEn, ExecEn, Done
  );

  modport slave (
    input  Start, Instr, Branch, FlagWrite, Flag, LoadOp, StatusEn, Zero, Neg, Target,
    output ProgCtr, FetchEn, ExecEn, Done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and FETCH -> EXEC (-> WAIT) sequencer for the 9-bit core.
// Holds the sbf* branch condition and Z/N status; resolves b and raises Done on halt.
module pc_sequencer #(
  parameter int            PW       = 10,
  parameter logic [PW-1:0] START_PC = '0,
  parameter logic [8:0]    HALT_OP  = 9'h1FF
) (
  input logic          Clk,
  input logic          Reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] COND_NE = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_LE = 3'd3;
  localparam logic [2:0] COND_JP = 3'd4;

  state_t        state, state_nx;
  logic [PW-1:0] pc, pc_nx, pc_inc;
  logic [2:0]    cond, cond_nx;
  logic          z, z_nx;
  logic          n, n_nx;
  logic          fetch_en, exec_en, done;
  logic          taken;
  logic          restart;

  assign pc_inc  = pc + PW'(1);
  assign restart = bus.Start && (state inside {S_FETCH, S_EXEC, S_WAIT});

  // Codes 5-7 can be latched by sbf* but never select a taken branch.
  always_comb begin
    case (cond)
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_LT: taken = n;
      COND_LE: taken = n | z;
      COND_JP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves one unassigned (no latch).
    state_nx = state;
    pc_nx    = pc;
    cond_nx  = cond;
    z_nx     = z;
    n_nx     = n;
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    done     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          state_nx = S_FETCH;
          pc_nx    = START_PC;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (bus.Instr == HALT_OP) begin
          state_nx = S_DONE;
        end else if (bus.LoadOp) begin
          state_nx = S_WAIT;
        end else begin
          exec_en  = 1'b1;
          state_nx = S_FETCH;
          if (bus.Branch && bus.FlagWrite) begin
            cond_nx = bus.Flag;
            pc_nx   = pc_inc;
          end else if (bus.Branch && taken) begin
            pc_nx = bus.Target;
          end else begin
            pc_nx = pc_inc;
          end
        end
      end
      S_WAIT: begin
        exec_en  = 1'b1;
        pc_nx    = pc_inc;
        state_nx = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (bus.Start) begin
          state_nx = S_FETCH;
          pc_nx    = START_PC;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (exec_en && bus.StatusEn) begin
      z_nx = bus.Zero;
      n_nx = bus.Neg;
    end

    // A restart squashes the instruction in flight: no strobe and no flag/status side effects.
    if (restart) begin
      state_nx = S_FETCH;
      pc_nx    = START_PC;
      cond_nx  = cond;
      z_nx     = z;
      n_nx     = n;
      exec_en  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      pc    <= START_PC;
      cond  <= COND_JP;
      z     <= 1'b0;
      n     <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cond  <= cond_nx;
      z     <= z_nx;
      n     <= n_nx;
    end
  end

  assign bus.ProgCtr = pc;
  assign bus.FetchEn = fetch_en;
  assign bus.ExecEn  = exec_en;
  assign bus.Done    = done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, hand sequences for multi-cycle corners,
// and a random program checked against an instruction-level model.
module tb_pc_sequencer;

  localparam logic [8:0] HALT = 9'h1FF;

  localparam int K_ALU   = 0;
  localparam int K_SBF   = 1;
  localparam int K_BR    = 2;
  localparam int K_LB    = 3;
  localparam int K_STORE = 4;
  localparam int K_HALT  = 5;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pc_sequencer_if #(.PW(10)) bus ();
  pc_sequencer_if #(.PW(4))  bus4 ();

  pc_sequencer #(.PW(10), .START_PC(10'd0), .HALT_OP(HALT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  pc_sequencer #(.PW(4), .START_PC(4'd3), .HALT_OP(HALT)) dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus4.slave)
  );

  typedef struct {
    logic [9:0] fetch_pc;
    logic [8:0] instr;
    logic       branch;
    logic       flag_write;
    logic [2:0] flag;
    logic       load_op;
    logic       status_en;
    logic       zero;
    logic       neg;
    logic [9:0] target;
    logic       exp_exec;
  } vec_t;

  typedef struct {
    int         kind;
    logic [8:0] instr;
    logic [2:0] flag;
    logic       zero;
    logic       neg;
    int         target;
  } rom_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start = 0; bus.Instr = 9'h000; bus.Branch = 0; bus.FlagWrite = 0; bus.Flag = 3'd0;
    bus.LoadOp = 0; bus.StatusEn = 0; bus.Zero = 0; bus.Neg = 0; bus.Target = 10'd0;
  endtask

  task automatic idle_inputs4();
    bus4.Start = 0; bus4.Instr = 9'h000; bus4.Branch = 0; bus4.FlagWrite = 0; bus4.Flag = 3'd0;
    bus4.LoadOp = 0; bus4.StatusEn = 0; bus4.Zero = 0; bus4.Neg = 0; bus4.Target = 4'd0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.Instr = v.instr; bus.Branch = v.branch; bus.FlagWrite = v.flag_write; bus.Flag = v.flag;
    bus.LoadOp = v.load_op; bus.StatusEn = v.status_en; bus.Zero = v.zero; bus.Neg = v.neg;
    bus.Target = v.target;
  endtask

  task automatic apply_rom(input rom_t e);
    bus.Instr     = e.instr;
    bus.Branch    = (e.kind == K_SBF) || (e.kind == K_BR);
    bus.FlagWrite = (e.kind == K_SBF);
    bus.Flag      = e.flag;
    bus.LoadOp    = (e.kind == K_LB);
    bus.StatusEn  = (e.kind == K_ALU);
    bus.Zero      = e.zero;
    bus.Neg       = e.neg;
    bus.Target    = 10'(e.target);
  endtask

  function automatic bit model_taken(input int c, input bit zf, input bit nf);
    case (c)
      0:       return !zf;
      1:       return zf;
      2:       return nf;
      3:       return nf || zf;
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  vec_t         vecs[20];
  rom_t         rom[64];
  logic [9:0]   pcs[$];
  int           edges;
  int           m_pc, m_cond;
  bit           m_z, m_n;
  rom_t         e;

  initial begin
    // Straight run from PC 0: {fetch_pc, instr, br, fw, flag, lb, st_en, zero, neg, target, exec}
    vecs[0]  = '{10'd0,    9'h010, 0, 0, 3'd0, 0, 1, 0, 0, 10'd0,    1}; // add
    vecs[1]  = '{10'd1,    9'h011, 0, 0, 3'd0, 0, 1, 1, 0, 10'd0,    1}; // sub, Z=1
    vecs[2]  = '{10'd2,    9'h120, 1, 1, 3'd1, 0, 0, 0, 0, 10'd0,    1}; // sbfeq
    vecs[3]  = '{10'd3,    9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd40,   1}; // b 40, taken
    vecs[4]  = '{10'd40,   9'h011, 0, 0, 3'd0, 0, 1, 0, 1, 10'd0,    1}; // sub, Z=0 N=1
    vecs[5]  = '{10'd41,   9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd10,   1}; // b, eq not taken
    vecs[6]  = '{10'd42,   9'h123, 1, 1, 3'd3, 0, 0, 0, 0, 10'd0,    1}; // sbfle
    vecs[7]  = '{10'd43,   9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd7,    1}; // b 7, taken
    vecs[8]  = '{10'd7,    9'h125, 1, 1, 3'd5, 0, 0, 0, 0, 10'd0,    1}; // sbf code 5
    vecs[9]  = '{10'd8,    9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd20,   1}; // b, never taken
    vecs[10] = '{10'd9,    9'h124, 1, 1, 3'd4, 0, 0, 0, 0, 10'd0,    1}; // sbf jp
    vecs[11] = '{10'd10,   9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd1023, 1}; // b 1023
    vecs[12] = '{10'd1023, 9'h010, 0, 0, 3'd0, 0, 1, 1, 0, 10'd0,    1}; // add Z=1, wraps
    vecs[13] = '{10'd0,    9'h088, 0, 0, 3'd0, 1, 0, 0, 0, 10'd0,    0}; // lb
    vecs[14] = '{10'd1,    9'h120, 1, 1, 3'd0, 0, 0, 0, 0, 10'd0,    1}; // sbfne
    vecs[15] = '{10'd2,    9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd30,   1}; // b, ne not taken
    vecs[16] = '{10'd3,    9'h122, 1, 1, 3'd2, 0, 0, 0, 1, 10'd0,    1}; // sbflt, Neg not latched
    vecs[17] = '{10'd4,    9'h140, 1, 0, 3'd0, 0, 0, 0, 0, 10'd100,  1}; // b, lt not taken
    vecs[18] = '{10'd5,    9'h088, 0, 0, 3'd0, 1, 0, 0, 0, 10'd0,    0}; // lb at 5
    vecs[19] = '{10'd6,    HALT,   0, 0, 3'd0, 0, 0, 0, 0, 10'd0,    0}; // halt

    idle_inputs();
    idle_inputs4();
    Reset = 1'b0;
    tick();
    tick();
    check("rst_progctr", bus.ProgCtr, 0);
    check("rst_fetch", bus.FetchEn, 0);
    check("rst_exec", bus.ExecEn, 0);
    check("rst_done", bus.Done, 0);
    check("rst_progctr4", bus4.ProgCtr, 3);
    Reset = 1'b1;
    tick();
    check("idle_fetch", bus.FetchEn, 0);

    // ---------------- table-driven program ----------------
    bus.Start = 1;
    tick();
    bus.Start = 0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("v%0d_fetch_en", i), bus.FetchEn, 1);
      check($sformatf("v%0d_fetch_pc", i), bus.ProgCtr, vecs[i].fetch_pc);
      tick();
      apply_vec(vecs[i]);
      #1;
      check($sformatf("v%0d_exec_en", i), bus.ExecEn, vecs[i].exp_exec);
      tick();
      idle_inputs();
      #1;
      if (vecs[i].instr == HALT) begin
        check($sformatf("v%0d_done", i), bus.Done, 1);
        check($sformatf("v%0d_halt_pc", i), bus.ProgCtr, vecs[i].fetch_pc);
      end else if (vecs[i].load_op) begin
        check($sformatf("v%0d_wait_exec", i), bus.ExecEn, 1);
        check($sformatf("v%0d_wait_fetch", i), bus.FetchEn, 0);
        tick();
      end
    end

    // ---------------- 3 adds then halt: Done 8 cycles after Start ----------------
    bus.Start = 1;
    tick();
    bus.Start = 0;
    check("restart_done_falls", bus.Done, 0);
    edges = 0;
    while (!bus.Done && edges < 20) begin
      if (bus.FetchEn) pcs.push_back(bus.ProgCtr);
      bus.Instr = (bus.ProgCtr == 10'd3) ? HALT : 9'h021;
      tick();
      edges++;
    end
    bus.Instr = 9'h000;
    check("done_cycle", edges, 8);
    check("straight_count", pcs.size(), 4);
    for (int i = 0; i < pcs.size(); i++) check($sformatf("straight_pc%0d", i), pcs[i], i);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_held", bus.Done, 1);
      check("done_pc_held", bus.ProgCtr, 3);
    end

    // ---------------- reset mid-EXEC with a store in flight ----------------
    bus.Start = 1;
    tick();
    bus.Start = 0;
    tick();
    bus.Branch = 1; bus.FlagWrite = 1; bus.Flag = 3'd4;
    tick();
    idle_inputs();
    tick();
    bus.Branch = 1; bus.Target = 10'd12;
    tick();
    idle_inputs();
    check("pre_store_pc", bus.ProgCtr, 12);
    tick();
    bus.Instr = 9'h0A5;
    #1;
    check("store_exec", bus.ExecEn, 1);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_exec", bus.ExecEn, 0);
    check("abort_pc", bus.ProgCtr, 0);
    check("abort_fetch", bus.FetchEn, 0);
    idle_inputs();
    bus.Start = 1;
    tick();
    check("reset_beats_start", bus.FetchEn, 0);
    bus.Start = 0;
    Reset = 1'b1;
    tick();
    check("post_reset_idle", bus.FetchEn, 0);
    bus.Start = 1;
    tick();
    bus.Start = 0;
    check("start_fetch", bus.FetchEn, 1);
    check("start_pc", bus.ProgCtr, 0);
    tick();
    bus.Branch = 1; bus.Target = 10'd33;
    #1;
    check("jp_exec", bus.ExecEn, 1);
    tick();
    idle_inputs();
    check("reset_cond_jp", bus.ProgCtr, 33);

    // ---------------- PW=4: wrap, then Start during WAIT ----------------
    bus4.Start = 1;
    tick();
    bus4.Start = 0;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("w%0d_pc", i), bus4.ProgCtr, (3 + i) % 16);
      tick();
      bus4.Instr = 9'h010;
      #1;
      check($sformatf("w%0d_exec", i), bus4.ExecEn, 1);
      tick();
      idle_inputs4();
    end
    check("wrap_pc", bus4.ProgCtr, 0);
    check("wrap_fetch", bus4.FetchEn, 1);
    tick();
    bus4.LoadOp = 1;
    #1;
    check("lb4_exec", bus4.ExecEn, 0);
    tick();
    idle_inputs4();
    bus4.Start = 1;
    #1;
    check("wait_squash", bus4.ExecEn, 0);
    tick();
    bus4.Start = 0;
    check("restart4_fetch", bus4.FetchEn, 1);
    check("restart4_pc", bus4.ProgCtr, 3);

    // ---------------- random program vs instruction-level model ----------------
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rom[i].kind   = (r < 30) ? K_ALU : (r < 45) ? K_SBF : (r < 65) ? K_BR :
                      (r < 78) ? K_LB  : (r < 95) ? K_STORE : K_HALT;
      rom[i].instr  = (rom[i].kind == K_HALT) ? HALT : 9'($urandom_range(0, 510));
      rom[i].flag   = 3'($urandom_range(0, 7));
      rom[i].zero   = 1'($urandom_range(0, 1));
      rom[i].neg    = 1'($urandom_range(0, 1));
      rom[i].target = $urandom_range(0, 63);
    end
    idle_inputs();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    m_pc = 0; m_cond = 4; m_z = 0; m_n = 0;
    bus.Start = 1;
    tick();
    bus.Start = 0;
    for (int k = 0; k < 300; k++) begin
      check("rnd_fetch_en", bus.FetchEn, 1);
      check("rnd_fetch_pc", bus.ProgCtr, m_pc);
      tick();
      e = rom[m_pc % 64];
      apply_rom(e);
      if ($urandom_range(0, 19) == 0) begin
        bus.Start = 1;
        #1;
        check("rnd_squash", bus.ExecEn, 0);
        tick();
        idle_inputs();
        m_pc = 0;
        continue;
      end
      #1;
      check("rnd_exec_en", bus.ExecEn, (e.kind == K_HALT || e.kind == K_LB) ? 0 : 1);
      tick();
      idle_inputs();
      #1;
      if (e.kind == K_HALT) begin
        check("rnd_done", bus.Done, 1);
        check("rnd_halt_pc", bus.ProgCtr, m_pc);
        bus.Start = 1;
        tick();
        bus.Start = 0;
        m_pc = 0;
      end else if (e.kind == K_LB) begin
        check("rnd_wait_exec", bus.ExecEn, 1);
        tick();
        m_pc = (m_pc + 1) % 1024;
      end else begin
        case (e.kind)
          K_ALU: begin
            m_z = e.zero;
            m_n = e.neg;
            m_pc = (m_pc + 1) % 1024;
          end
          K_SBF: begin
            m_cond = int'(e.flag);
            m_pc = (m_pc + 1) % 1024;
          end
          K_BR:    m_pc = model_taken(m_cond, m_z, m_n) ? e.target : (m_pc + 1) % 1024;
          default: m_pc = (m_pc + 1) % 1024;
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
